// File: rtl/bcd_display_scan_4digit.sv
// Four-digit common-anode 7-segment scanner: snapshots the BCD digits once per
// frame, multiplexes them with leading-zero blanking, dash for invalid codes and dp.
module bcd_display_scan_4digit #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic [3:0] dp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} slot_t;

  slot_t          slot;
  slot_t          slot_next;
  logic [CW-1:0]  presc;
  logic           tc;
  logic [3:0]     snap0, snap1, snap2, snap3, snap_dp;
  logic [3:0]     cur;
  logic           cur_dp;
  logic           blank;
  logic [3:0]     an_c;
  logic [6:0]     seg_c;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  assign tc = (presc == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tc) begin
      presc <= '0;
    end else begin
      presc <= presc + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= S0;
    end else begin
      slot <= slot_next;
    end
  end

  always_comb begin
    slot_next = slot;
    if (tc) begin
      case (slot)
        S0:      slot_next = S1;
        S1:      slot_next = S2;
        S2:      slot_next = S3;
        S3:      slot_next = S0;
        default: slot_next = S0;
      endcase
    end else begin
      slot_next = slot;
    end
  end

  // The whole frame is captured at once so a displayed frame never mixes two input samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap0       <= 4'd0;
      snap1       <= 4'd0;
      snap2       <= 4'd0;
      snap3       <= 4'd0;
      snap_dp     <= 4'd0;
      frame_start <= 1'b0;
    end else if (tc && (slot == S3)) begin
      snap0       <= dig0;
      snap1       <= dig1;
      snap2       <= dig2;
      snap3       <= dig3;
      snap_dp     <= dp_en;
      frame_start <= 1'b1;
    end else begin
      frame_start <= 1'b0;
    end
  end

  always_comb begin
    cur    = snap0;
    cur_dp = snap_dp[0];
    blank  = 1'b0;
    an_c   = 4'b0001;
    case (slot)
      S0: begin
        cur    = snap0;
        cur_dp = snap_dp[0];
        an_c   = 4'b0001;
      end
      S1: begin
        cur    = snap1;
        cur_dp = snap_dp[1];
        blank  = BLANK_LEADING && (snap3 == 4'd0) && (snap2 == 4'd0) && (snap1 == 4'd0);
        an_c   = 4'b0010;
      end
      S2: begin
        cur    = snap2;
        cur_dp = snap_dp[2];
        blank  = BLANK_LEADING && (snap3 == 4'd0) && (snap2 == 4'd0);
        an_c   = 4'b0100;
      end
      S3: begin
        cur    = snap3;
        cur_dp = snap_dp[3];
        blank  = BLANK_LEADING && (snap3 == 4'd0);
        an_c   = 4'b1000;
      end
      default: begin
        cur    = snap0;
        cur_dp = snap_dp[0];
        an_c   = 4'b0001;
      end
    endcase
    seg_c = blank ? 7'h00 : decode(cur);
  end

  // Pin polarity is applied as a final XOR so the decode stays in active-high form.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= {4{ACTIVE_LOW}};
      seg <= {7{ACTIVE_LOW}};
      dp  <= ACTIVE_LOW;
    end else begin
      an  <= an_c ^ {4{ACTIVE_LOW}};
      seg <= seg_c ^ {7{ACTIVE_LOW}};
      dp  <= cur_dp ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan_4digit.sv
// Self-checking bench: two scanner instances (active-low/blanking, active-high/no blanking)
// compared cycle by cycle against a time-indexed behavioural model.
module tb_bcd_display_scan_4digit;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dig0 = 4'd0, dig1 = 4'd0, dig2 = 4'd0, dig3 = 4'd0, dp_en = 4'd0;
  logic [3:0] an, an2;
  logic [6:0] seg, seg2;
  logic       dp, dp2, frame_start, frame_start2;

  int tests = 0;
  int fails = 0;

  bcd_display_scan_4digit #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dp_en(dp_en),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start));

  bcd_display_scan_4digit #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b0)) dut2 (
    .clk(clk), .rst(rst), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dp_en(dp_en),
    .an(an2), .seg(seg2), .dp(dp2), .frame_start(frame_start2));

  always #5 clk = ~clk;

  // Model: k counts running cycles since reset; the shown digit and frame boundary follow from k.
  int         k;
  logic [15:0] mdig;
  logic [3:0]  mdp;
  logic [3:0]  e_an, e_an2;
  logic [6:0]  e_seg, e_seg2;
  logic        e_dp, e_dp2, e_fs;

  function automatic logic [6:0] exp_seg(input logic [15:0] d, input int s, input bit blank, input bit al);
    logic [6:0] tbl [0:9];
    logic [6:0] r;
    int v;
    bit zero_above;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    v = int'(d[4*s +: 4]);
    zero_above = 1'b1;
    for (int i = s; i < 4; i++) if (d[4*i +: 4] != 4'd0) zero_above = 1'b0;
    r = (v < 10) ? tbl[v] : 7'h40;
    if (blank && s > 0 && zero_above) r = 7'h00;
    return al ? ~r : r;
  endfunction

  function automatic logic [3:0] exp_an(input int s, input bit al);
    logic [3:0] a;
    a = 4'b0001 << s;
    return al ? ~a : a;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      k <= 0; mdig <= 16'h0000; mdp <= 4'h0;
      e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_fs <= 1'b0;
      e_an2 <= 4'h0; e_seg2 <= 7'h00; e_dp2 <= 1'b0;
    end else begin
      e_an   <= exp_an((k / DIV) % 4, 1'b1);
      e_seg  <= exp_seg(mdig, (k / DIV) % 4, 1'b1, 1'b1);
      e_dp   <= ~mdp[(k / DIV) % 4];
      e_an2  <= exp_an((k / DIV) % 4, 1'b0);
      e_seg2 <= exp_seg(mdig, (k / DIV) % 4, 1'b0, 1'b0);
      e_dp2  <= mdp[(k / DIV) % 4];
      if (k % FRAME == FRAME - 1) begin
        mdig <= {dig3, dig2, dig1, dig0};
        mdp  <= dp_en;
        e_fs <= 1'b1;
      end else begin
        e_fs <= 1'b0;
      end
      k <= k + 1;
    end
  end

  task automatic set_digits(input logic [15:0] v, input logic [3:0] d);
    {dig3, dig2, dig1, dig0} = v;
    dp_en = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_digits(16'h9876, 4'hF);
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if ({an, seg, dp, frame_start, an2, seg2, dp2, frame_start2} !== {4'hF, 7'h7F, 1'b1, 1'b0, 4'h0, 7'h00, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL reset: an=%b seg=%h dp=%b fs=%b an2=%b seg2=%h dp2=%b, expected inactive levels", an, seg, dp, frame_start, an2, seg2, dp2);
      end
    end
    set_digits(16'h0000, 4'h0);
  endtask

  task automatic test_scan;
    rst = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk); #1;
      if (i == 0) set_digits(16'h1234, 4'h0);
      tests++;
      if ({an, seg, dp, frame_start, an2, seg2, dp2, frame_start2} !== {e_an, e_seg, e_dp, e_fs, e_an2, e_seg2, e_dp2, e_fs}) begin
        fails++;
        $display("FAIL scan cyc%0d: got an=%b seg=%h dp=%b fs=%b | %b %h %b %b, expected %b %h %b %b | %b %h %b", i, an, seg, dp, frame_start, an2, seg2, dp2, frame_start2, e_an, e_seg, e_dp, e_fs, e_an2, e_seg2, e_dp2);
      end
      if (i == 0 || i == FRAME) begin
        tests++;
        if ({an, seg} !== ((i == 0) ? {4'b1110, 7'h40} : {4'b1110, ~7'h66})) begin
          fails++;
          $display("FAIL scan_s0_cyc%0d: an=%b seg=%h", i, an, seg);
        end
      end
    end
  endtask

  task automatic test_coherence;
    set_digits(16'h0012, 4'h0);
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clk); #1;
      if (i == FRAME + DIV + 1) set_digits(16'h0099, 4'h0);
      tests++;
      if ({an, seg, dp, frame_start, an2, seg2, dp2, frame_start2} !== {e_an, e_seg, e_dp, e_fs, e_an2, e_seg2, e_dp2, e_fs}) begin
        fails++;
        $display("FAIL coherence cyc%0d: got an=%b seg=%h fs=%b | %b %h, expected %b %h %b | %b %h", i, an, seg, frame_start, an2, seg2, e_an, e_seg, e_fs, e_an2, e_seg2);
      end
    end
  endtask

  task automatic test_blanking;
    logic [15:0] cases [0:3];
    cases = '{16'h0000, 16'h0005, 16'h0105, 16'h1000};
    for (int c = 0; c < 5; c++) begin
      if (c < 4) set_digits(cases[c], 4'h0);
      repeat (FRAME) begin
        @(posedge clk); #1;
        tests++;
        if ({an, seg, dp, frame_start, an2, seg2, dp2, frame_start2} !== {e_an, e_seg, e_dp, e_fs, e_an2, e_seg2, e_dp2, e_fs}) begin
          fails++;
          $display("FAIL blanking case%0d: got an=%b seg=%h | %b %h, expected %b %h | %b %h", c, an, seg, an2, seg2, e_an, e_seg, e_an2, e_seg2);
        end
      end
    end
  endtask

  task automatic test_invalid_dp;
    set_digits(16'h00C0, 4'b0100);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({an, seg, dp, frame_start, an2, seg2, dp2, frame_start2} !== {e_an, e_seg, e_dp, e_fs, e_an2, e_seg2, e_dp2, e_fs}) begin
        fails++;
        $display("FAIL invalid_dp cyc%0d: got an=%b seg=%h dp=%b | %b %h %b, expected %b %h %b | %b %h %b", i, an, seg, dp, an2, seg2, dp2, e_an, e_seg, e_dp, e_an2, e_seg2, e_dp2);
      end
      if (i >= FRAME + 1) begin
        tests++;
        if (dp !== (an != 4'b1011)) begin
          fails++;
          $display("FAIL dp_slot2: an=%b dp=%b", an, dp);
        end
      end
    end
  endtask

  task automatic test_midframe_reset;
    set_digits(16'h9876, 4'h0);
    repeat (2 * DIV + 1) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL midreset: an=%b seg=%h dp=%b fs=%b, expected f 7f 1 0", an, seg, dp, frame_start);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({an, seg, dp, frame_start, an2, seg2, dp2, frame_start2} !== {e_an, e_seg, e_dp, e_fs, e_an2, e_seg2, e_dp2, e_fs}) begin
        fails++;
        $display("FAIL midreset cyc%0d: got an=%b seg=%h fs=%b, expected %b %h %b", i, an, seg, frame_start, e_an, e_seg, e_fs);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40 * FRAME; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({an, seg, dp, frame_start, an2, seg2, dp2, frame_start2} !== {e_an, e_seg, e_dp, e_fs, e_an2, e_seg2, e_dp2, e_fs}) begin
        fails++;
        $display("FAIL random cyc%0d: got an=%b seg=%h dp=%b fs=%b | %b %h %b, expected %b %h %b %b | %b %h %b", i, an, seg, dp, frame_start, an2, seg2, dp2, e_an, e_seg, e_dp, e_fs, e_an2, e_seg2, e_dp2);
      end
      if ($urandom_range(3, 0) == 0) begin
        // Bias toward zeros so blanking paths are exercised often.
        dig0 = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 0));
        dig1 = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 0));
        dig2 = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 0));
        dig3 = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 0));
        dp_en = 4'($urandom_range(15, 0));
      end
      rst = ($urandom_range(199, 0) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_scan;
    test_coherence;
    test_blanking;
    test_invalid_dp;
    test_midframe_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
